// File: rtl/dsp_host_ram_bridge.sv
// dsp_host_ram_bridge
//   Host-side access stage for port B of the DSP data RAM (2^ADDR_W x 16).
//   Turns 8-bit, byte-addressed host reads/writes into 16-bit word accesses.
//   A byte write is a read-modify-write because port B has one write enable
//   covering both bytes. Port A stays with the DSP core.
//
//   Optional feature (define DSP_HOST_PREFETCH_EN):
//     one-word cache of the last word read or merged. A read hit completes
//     without touching the RAM. The entry is dropped on a DSP port A write
//     to the cached word.
//
// Ports
//   clk_i, rst_ni      clock (also RAM port B clock), async active-low reset
//   host_rd_i/wr_i     one-cycle request strobes (write wins if both high)
//   host_addr_i        byte address, bit 0 selects the high byte
//   host_din_i         write data
//   host_dout_o        read data, held until the next read completes
//   host_busy_o        request in flight
//   host_ack_o         one-cycle completion pulse
//   ram_*              RAM port B (bypass read: data valid the cycle after ce)
//   dsp_we_i, dsp_ad_i port A write snoop (used only with the cache)
module dsp_host_ram_bridge #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              host_rd_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W:0]   host_addr_i,
    input  logic [7:0]        host_din_i,
    output logic [7:0]        host_dout_o,
    output logic              host_busy_o,
    output logic              host_ack_o,
    output logic [ADDR_W-1:0] ram_ad_o,
    output logic [15:0]       ram_din_o,
    input  logic [15:0]       ram_dout_i,
    output logic              ram_ce_o,
    output logic              ram_oce_o,
    output logic              ram_wre_o,
    input  logic              dsp_we_i,
    input  logic [ADDR_W-1:0] dsp_ad_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCap,
        StWrIssue,
        StWrCap,
        StWrCommit,
        StDone
    } state_e;

    state_e            state_q;
    logic [7:0]        host_dout_q;
    logic              host_busy_q;
    logic              host_ack_q;
    logic [ADDR_W-1:0] ram_ad_q;
    logic [15:0]       ram_din_q;
    logic              ram_ce_q;
    logic              ram_wre_q;
    logic              sel_q;   // 1: high byte
    logic [7:0]        din_q;

    logic [15:0] merged;
    logic [7:0]  rd_byte;
    logic        rd_hit;

    assign merged  = sel_q ? {din_q, ram_dout_i[7:0]} : {ram_dout_i[15:8], din_q};
    assign rd_byte = sel_q ? ram_dout_i[15:8] : ram_dout_i[7:0];

`ifdef DSP_HOST_PREFETCH_EN
    logic [15:0]       cache_q;
    logic [ADDR_W-1:0] cache_ad_q;
    logic              cache_vld_q;

    // A DSP write to the same word in the same cycle makes the entry stale.
    assign rd_hit = cache_vld_q && (cache_ad_q == host_addr_i[ADDR_W:1]) &&
                    !(dsp_we_i && (dsp_ad_i == host_addr_i[ADDR_W:1]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cache_q     <= '0;
            cache_ad_q  <= '0;
            cache_vld_q <= 1'b0;
        end else if (state_q == StRdCap || state_q == StWrCap) begin
            cache_q     <= (state_q == StRdCap) ? ram_dout_i : merged;
            cache_ad_q  <= ram_ad_q;
            cache_vld_q <= !(dsp_we_i && (dsp_ad_i == ram_ad_q));
        end else if (dsp_we_i && (dsp_ad_i == cache_ad_q)) begin
            cache_vld_q <= 1'b0;
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{dsp_we_i, dsp_ad_i};
    assign rd_hit       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            host_dout_q <= '0;
            host_busy_q <= 1'b0;
            host_ack_q  <= 1'b0;
            ram_ad_q    <= '0;
            ram_din_q   <= '0;
            ram_ce_q    <= 1'b0;
            ram_wre_q   <= 1'b0;
            sel_q       <= 1'b0;
            din_q       <= '0;
        end else begin
            host_ack_q <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_wre_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host_wr_i || host_rd_i) begin
                        ram_ad_q <= host_addr_i[ADDR_W:1];
                        sel_q    <= host_addr_i[0];
                        din_q    <= host_din_i;
                    end
                    if (host_wr_i) begin
                        ram_ce_q    <= 1'b1;
                        host_busy_q <= 1'b1;
                        state_q     <= StWrIssue;
                    end else if (host_rd_i && rd_hit) begin
`ifdef DSP_HOST_PREFETCH_EN
                        host_dout_q <= host_addr_i[0] ? cache_q[15:8] : cache_q[7:0];
`endif
                        host_ack_q  <= 1'b1;
                        state_q     <= StDone;
                    end else if (host_rd_i) begin
                        ram_ce_q    <= 1'b1;
                        host_busy_q <= 1'b1;
                        state_q     <= StRdIssue;
                    end
                end
                StRdIssue: state_q <= StRdCap;
                StRdCap: begin
                    host_dout_q <= rd_byte;
                    host_ack_q  <= 1'b1;
                    host_busy_q <= 1'b0;
                    state_q     <= StDone;
                end
                StWrIssue: state_q <= StWrCap;
                StWrCap: begin
                    ram_din_q <= merged;
                    ram_ce_q  <= 1'b1;
                    ram_wre_q <= 1'b1;
                    state_q   <= StWrCommit;
                end
                StWrCommit: begin
                    host_ack_q  <= 1'b1;
                    host_busy_q <= 1'b0;
                    state_q     <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign host_dout_o = host_dout_q;
    assign host_busy_o = host_busy_q;
    assign host_ack_o  = host_ack_q;
    assign ram_ad_o    = ram_ad_q;
    assign ram_din_o   = ram_din_q;
    assign ram_ce_o    = ram_ce_q;
    assign ram_wre_o   = ram_wre_q;
    assign ram_oce_o   = 1'b1;

endmodule

// File: tb/tb_dsp_host_ram_bridge.sv
// Directed bench for dsp_host_ram_bridge with a behavioural port-B RAM.
module tb_dsp_host_ram_bridge;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          rst_n;
    logic          host_rd;
    logic          host_wr;
    logic [AW:0]   host_addr;
    logic [7:0]    host_din;
    logic [7:0]    host_dout;
    logic          host_busy;
    logic          host_ack;
    logic [AW-1:0] ram_ad;
    logic [15:0]   ram_din;
    logic [15:0]   ram_dout;
    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;
    logic          dsp_we;
    logic [AW-1:0] dsp_ad;

    logic [15:0] mem [0:(1<<AW)-1];
    int total = 0;
    int bad   = 0;
    int ce_cnt = 0;
    int wre_cnt = 0;
    int ack_cnt = 0;

    dsp_host_ram_bridge #(.ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .host_rd_i   (host_rd),
        .host_wr_i   (host_wr),
        .host_addr_i (host_addr),
        .host_din_i  (host_din),
        .host_dout_o (host_dout),
        .host_busy_o (host_busy),
        .host_ack_o  (host_ack),
        .ram_ad_o    (ram_ad),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout),
        .ram_ce_o    (ram_ce),
        .ram_oce_o   (ram_oce),
        .ram_wre_o   (ram_wre),
        .dsp_we_i    (dsp_we),
        .dsp_ad_i    (dsp_ad)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Port B RAM, bypass read: data valid the cycle after ce.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
        if (ram_ce)   ce_cnt  <= ce_cnt + 1;
        if (ram_wre)  wre_cnt <= wre_cnt + 1;
        if (host_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = cycle index of ack (accept cycle is 0), -1 on timeout.
    // Returns after stepping from DONE into IDLE.
    task automatic do_req(input logic rd, input logic wr, input logic [AW:0] addr,
                          input logic [7:0] din, output int lat);
        host_rd = rd; host_wr = wr; host_addr = addr; host_din = din;
        tick();
        host_rd = 1'b0; host_wr = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (host_ack) begin
                lat = n;
                break;
            end
            tick();
        end
        chk("busy_low_at_ack", {31'd0, host_busy}, 32'd0);
        tick();
    endtask

    int lat;
    int ce0;
    int wre0;
    int ack0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
        rst_n = 1'b0; host_rd = 1'b0; host_wr = 1'b0; host_addr = '0; host_din = '0;
        dsp_we = 1'b0; dsp_ad = '0;
        tick(); tick();
        chk("rst_dout", {24'd0, host_dout}, 32'h0);
        chk("rst_busy", {31'd0, host_busy}, 32'h0);
        chk("rst_ack",  {31'd0, host_ack},  32'h0);
        chk("rst_ram_ad", {21'd0, ram_ad}, 32'h0);
        chk("rst_ram_din", {16'd0, ram_din}, 32'h0);
        chk("rst_ce",  {31'd0, ram_ce},  32'h0);
        chk("rst_wre", {31'd0, ram_wre}, 32'h0);
        chk("rst_oce", {31'd0, ram_oce}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Reads of word 0x005 = 0xBEEF
        mem[11'h005] = 16'hBEEF;
        ce0 = ce_cnt;
        do_req(1'b1, 1'b0, 12'h00A, 8'h00, lat);
        chk("rd_lo_lat", lat, 32'd3);
        chk("rd_lo_dout", {24'd0, host_dout}, 32'hEF);
        chk("rd_lo_ce_pulses", ce_cnt - ce0, 32'd1);
        do_req(1'b1, 1'b0, 12'h00B, 8'h00, lat);
        chk("rd_hi_dout", {24'd0, host_dout}, 32'hBE);

        // Byte write to the top byte address
        mem[11'h7FF] = 16'h1234;
        wre0 = wre_cnt;
        do_req(1'b0, 1'b1, 12'hFFF, 8'hAB, lat);
        chk("wr_top_lat", lat, 32'd4);
        chk("wr_top_word", {16'd0, mem[11'h7FF]}, 32'hAB34);
        chk("wr_top_wre_pulses", wre_cnt - wre0, 32'd1);
        chk("wr_keeps_dout", {24'd0, host_dout}, 32'hBE);

        // Simultaneous read and write: write wins
        ack0 = ack_cnt;
        do_req(1'b1, 1'b1, 12'h010, 8'h55, lat);
        repeat (3) tick();
        chk("rdwr_lat", lat, 32'd4);
        chk("rdwr_word", {16'd0, mem[11'h008]}, 32'h0055);
        chk("rdwr_dout", {24'd0, host_dout}, 32'hBE);
        chk("rdwr_acks", ack_cnt - ack0, 32'd1);

        // Read strobe one cycle after a write is accepted is ignored
        mem[11'h010] = 16'h1111;
        ack0 = ack_cnt; ce0 = ce_cnt; wre0 = wre_cnt;
        host_wr = 1'b1; host_addr = 12'h020; host_din = 8'h77;
        tick();
        host_wr = 1'b0; host_rd = 1'b1; host_addr = 12'h00A;
        tick();
        host_rd = 1'b0;
        repeat (8) tick();
        chk("busy_acks", ack_cnt - ack0, 32'd1);
        chk("busy_word", {16'd0, mem[11'h010]}, 32'h1177);
        chk("busy_dout", {24'd0, host_dout}, 32'hBE);
        chk("busy_ce_pulses", ce_cnt - ce0, 32'd2);
        chk("busy_wre_pulses", wre_cnt - wre0, 32'd1);

        // Reset during WR_CAP
        mem[11'h030] = 16'h5A5A;
        wre0 = wre_cnt;
        host_wr = 1'b1; host_addr = 12'h061; host_din = 8'h99;
        tick();                 // accept, now WR_ISSUE
        host_wr = 1'b0;
        tick();                 // now WR_CAP
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", {24'd0, host_dout}, 32'h0);
        chk("mid_rst_busy", {31'd0, host_busy}, 32'h0);
        chk("mid_rst_ack",  {31'd0, host_ack},  32'h0);
        chk("mid_rst_ram_ad", {21'd0, ram_ad}, 32'h0);
        chk("mid_rst_ram_din", {16'd0, ram_din}, 32'h0);
        chk("mid_rst_ce",  {31'd0, ram_ce},  32'h0);
        chk("mid_rst_wre", {31'd0, ram_wre}, 32'h0);
        chk("mid_rst_oce", {31'd0, ram_oce}, 32'h1);
        tick(); tick();
        #2 rst_n = 1'b1;
        repeat (4) tick();
        chk("mid_rst_no_wre", wre_cnt - wre0, 32'd0);
        chk("mid_rst_word", {16'd0, mem[11'h030]}, 32'h5A5A);
        do_req(1'b1, 1'b0, 12'h061, 8'h00, lat);
        chk("post_rst_rd_lat", lat, 32'd3);
        chk("post_rst_rd_dout", {24'd0, host_dout}, 32'h5A);

        // Repeated read of one word (cache path when enabled)
        mem[11'h020] = 16'hCAFE;
        do_req(1'b1, 1'b0, 12'h040, 8'h00, lat);
        chk("pf_first_lat", lat, 32'd3);
        chk("pf_first_dout", {24'd0, host_dout}, 32'hFE);
        ce0 = ce_cnt;
        do_req(1'b1, 1'b0, 12'h041, 8'h00, lat);
        chk("pf_second_dout", {24'd0, host_dout}, 32'hCA);
`ifdef DSP_HOST_PREFETCH_EN
        chk("pf_hit_lat", lat, 32'd1);
        chk("pf_hit_ce_pulses", ce_cnt - ce0, 32'd0);
`else
        chk("pf_second_lat", lat, 32'd3);
        chk("pf_second_ce_pulses", ce_cnt - ce0, 32'd1);
`endif
        // DSP write to the word, then read again: must come from RAM
        dsp_we = 1'b1; dsp_ad = 11'h020; mem[11'h020] = 16'hD00D;
        tick();
        dsp_we = 1'b0;
        ce0 = ce_cnt;
        do_req(1'b1, 1'b0, 12'h041, 8'h00, lat);
        chk("pf_inval_lat", lat, 32'd3);
        chk("pf_inval_ce_pulses", ce_cnt - ce0, 32'd1);
        chk("pf_inval_dout", {24'd0, host_dout}, 32'hD0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
